bip_acc_datapath_v2: RTL

Second-generation accumulator datapath for the BIP processor. It is parametrised in data, operand and address width, and supports a configurable data-RAM read latency. Adds an 8-function ALU, sign-extended immediates, Z/N/C status flags, and a micro-op FSM with start/busy/done handshake toward the control unit. Sits between the control unit and the data RAM.

---
 rtl/bip_acc_datapath_v2.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bip_acc_datapath_v2.sv
// BIP accumulator datapath, second generation: 8-function ALU, Z/N/C flags and
// a start/busy/done micro-op sequencer in front of a data RAM of configurable read latency.
module bip_acc_datapath_v2 #(
   parameter int NB_DATA     = 16,
   parameter int NB_OPERAND  = 11,
   parameter int NB_ADDR     = 11,
   parameter int NB_SEL_A    = 2,
   parameter int NB_OP       = 3,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [NB_OPERAND-1:0] i_operand,
   input  logic [NB_SEL_A-1:0]   i_sel_a,
   input  logic                  i_sel_b,
   input  logic [NB_OP-1:0]      i_op,
   input  logic                  i_wr_mem,
   input  logic [NB_DATA-1:0]    i_ram_rdata,
   output logic [NB_ADDR-1:0]    o_ram_addr,
   output logic                  o_ram_rd,
   output logic                  o_ram_wr,
   output logic [NB_DATA-1:0]    o_ram_wdata,
   output logic [NB_DATA-1:0]    o_acc,
   output logic                  o_flag_z,
   output logic                  o_flag_n,
   output logic                  o_flag_c,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int NB_CNT = $clog2(RAM_LATENCY + 1);

   localparam logic [NB_SEL_A-1:0] SEL_RAM = NB_SEL_A'(0);
   localparam logic [NB_SEL_A-1:0] SEL_IMM = NB_SEL_A'(1);
   localparam logic [NB_SEL_A-1:0] SEL_ALU = NB_SEL_A'(2);

   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(0);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(1);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(2);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(3);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(4);
   localparam logic [NB_OP-1:0] OP_SHL = NB_OP'(5);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_EXEC,
      ST_STORE
   } state_t;

   state_t                  state_q;
   logic [NB_CNT-1:0]       cnt_q;
   logic [NB_OPERAND-1:0]   operand_q;
   logic [NB_SEL_A-1:0]     sel_a_q;
   logic                    sel_b_q;
   logic [NB_OP-1:0]        op_q;
   logic [NB_DATA-1:0]      acc_q;
   logic                    z_q, n_q, c_q;
   logic                    rd_q, wr_q, done_q;

   logic [NB_DATA-1:0]      imm;
   logic [NB_DATA-1:0]      alu_b, alu_res;
   logic                    alu_c;
   logic [NB_DATA:0]        sum, diff;
   logic [NB_DATA-1:0]      acc_d;
   logic                    z_d, n_d, c_d;
   logic                    upd_zn, upd_c;
   logic                    need_ram;

   generate
      if (NB_DATA > NB_OPERAND) begin : g_sext
         assign imm = {{(NB_DATA-NB_OPERAND){operand_q[NB_OPERAND-1]}}, operand_q};
      end else begin : g_trunc
         assign imm = operand_q[NB_DATA-1:0];
      end
   endgenerate

   always_comb begin
      alu_b   = sel_b_q ? imm : i_ram_rdata;
      sum     = {1'b0, acc_q} + {1'b0, alu_b};
      diff    = {1'b0, acc_q} - {1'b0, alu_b};
      alu_res = alu_b;
      alu_c   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res = sum[NB_DATA-1:0];
            alu_c   = sum[NB_DATA];
         end
         OP_SUB: begin
            // Carry reads as "no borrow": set when A >= B unsigned.
            alu_res = diff[NB_DATA-1:0];
            alu_c   = ~diff[NB_DATA];
         end
         OP_AND: alu_res = acc_q & alu_b;
         OP_OR:  alu_res = acc_q | alu_b;
         OP_XOR: alu_res = acc_q ^ alu_b;
         OP_SHL: begin
            alu_res = {acc_q[NB_DATA-2:0], 1'b0};
            alu_c   = acc_q[NB_DATA-1];
         end
         OP_SRA: begin
            alu_res = {acc_q[NB_DATA-1], acc_q[NB_DATA-1:1]};
            alu_c   = acc_q[0];
         end
         default: alu_res = alu_b;
      endcase
   end

   // Accumulator / flag candidates for the completing cycle of a load or ALU op.
   always_comb begin
      acc_d  = acc_q;
      upd_zn = 1'b0;
      upd_c  = 1'b0;
      case (sel_a_q)
         SEL_RAM: begin
            acc_d  = i_ram_rdata;
            upd_zn = 1'b1;
         end
         SEL_IMM: begin
            acc_d  = imm;
            upd_zn = 1'b1;
         end
         SEL_ALU: begin
            acc_d  = alu_res;
            upd_zn = 1'b1;
            upd_c  = 1'b1;
         end
         default: acc_d = acc_q;
      endcase
      z_d = upd_zn ? (acc_d == '0) : z_q;
      n_d = upd_zn ? acc_d[NB_DATA-1] : n_q;
      c_d = upd_c ? alu_c : c_q;
   end

   assign need_ram = (i_sel_a == SEL_RAM) || ((i_sel_a == SEL_ALU) && !i_sel_b);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         operand_q <= '0;
         sel_a_q   <= '0;
         sel_b_q   <= 1'b0;
         op_q      <= '0;
         acc_q     <= '0;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         c_q       <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  operand_q <= i_operand;
                  sel_a_q   <= i_sel_a;
                  sel_b_q   <= i_sel_b;
                  op_q      <= i_op;
                  if (i_wr_mem) begin
                     state_q <= ST_STORE;
                     wr_q    <= 1'b1;
                  end else if (need_ram) begin
                     state_q <= ST_RD;
                     rd_q    <= 1'b1;
                  end else begin
                     state_q <= ST_EXEC;
                  end
               end
            end
            ST_RD: begin
               cnt_q   <= NB_CNT'(RAM_LATENCY);
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == NB_CNT'(1)) begin
                  acc_q   <= acc_d;
                  z_q     <= z_d;
                  n_q     <= n_d;
                  c_q     <= c_d;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
               cnt_q <= cnt_q - NB_CNT'(1);
            end
            ST_EXEC: begin
               acc_q   <= acc_d;
               z_q     <= z_d;
               n_q     <= n_d;
               c_q     <= c_d;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            ST_STORE: begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_ram_addr  = operand_q[NB_ADDR-1:0];
   assign o_ram_rd    = rd_q;
   assign o_ram_wr    = wr_q;
   assign o_ram_wdata = acc_q;
   assign o_acc       = acc_q;
   assign o_flag_z    = z_q;
   assign o_flag_n    = n_q;
   assign o_flag_c    = c_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = done_q;

endmodule
